// File: rtl/uart_tx_fifo_if.sv
// Handshake/status bundle between the CSR/TX FSM side and the TX FIFO.
// The FIFO side uses the slave modport.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              ovf_clr;
    logic              tx_data_ready;
    logic              send;
    logic [DATA_W-1:0] tx_data;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  level;
    logic              overflow;
    logic              level_irq;

    modport master (
        output wr_en, wr_data, flush, ovf_clr, tx_data_ready,
        input  send, tx_data, full, empty, level, overflow, level_irq
    );

    modport slave (
        input  wr_en, wr_data, flush, ovf_clr, tx_data_ready,
        output send, tx_data, full, empty, level, overflow, level_irq
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead transmit FIFO feeding the UART TX FSM with level/overflow status.
// Define UART_TX_FIFO_LEVEL_IRQ_EN to build the registered low-level interrupt.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
    ,
    parameter int IRQ_THRESH = DEPTH / 4
`endif
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              is_full;
    logic              is_empty;
    logic              pop;
    logic              push;
    logic              drop;

    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);

    // flush wins over both sides, and a discarded write is not an overflow
    assign pop  = ~is_empty & bus.tx_data_ready & ~bus.flush;
    assign push = bus.wr_en & (~is_full | pop) & ~bus.flush;
    assign drop = bus.wr_en & is_full & ~pop & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push & ~pop)
                cnt <= cnt + CNT_W'(1);
            else if (pop & ~push)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (bus.ovf_clr)
            ovf <= 1'b0;
    end

    assign bus.send     = ~is_empty;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.level    = cnt;
    assign bus.overflow = ovf;
    // gated so the head reads as zero whenever nothing is queued
    assign bus.tx_data  = is_empty ? '0 : mem[rd_ptr];

`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
    logic irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= (cnt <= CNT_W'(IRQ_THRESH));
    end

    assign bus.level_irq = irq;
`else
    assign bus.level_irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed plus randomized bench for uart_tx_fifo against a queue-based model.
// Honours UART_TX_FIFO_LEVEL_IRQ_EN with a threshold of 4.
module tb_uart_tx_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int THR    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [DATA_W-1:0] q [$];
    logic              m_ovf = 1'b0;
    logic              m_irq = 1'b0;

    uart_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IRQ_THRESH(THR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
`else
    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".level"}, 32'(bus.level), 32'(q.size()));
        chk({tag, ".send"}, 32'(bus.send), 32'(q.size() != 0));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".tx_data"}, 32'(bus.tx_data), 32'(head));
        chk({tag, ".irq"}, 32'(bus.level_irq), 32'(m_irq));
    endtask

    // one clock: drive, advance, update model, compare
    task automatic cyc(input string tag, input logic wr,
                       input logic [DATA_W-1:0] d, input logic rdy,
                       input logic fl, input logic oc);
        logic irq_n;
        logic dropped;
        logic [DATA_W-1:0] tmp;
        bus.wr_en         = wr;
        bus.wr_data       = d;
        bus.tx_data_ready = rdy;
        bus.flush         = fl;
        bus.ovf_clr       = oc;
`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
        irq_n = (q.size() <= THR);
`else
        irq_n = 1'b0;
`endif
        if (!fl && q.size() != 0 && rdy)
            chk({tag, ".pop_data"}, 32'(bus.tx_data), 32'(q[0]));
        @(posedge clk);
        #1;
        dropped = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && rdy)
                tmp = q.pop_front();
            if (wr) begin
                if (q.size() < DEPTH)
                    q.push_back(d);
                else
                    dropped = 1'b1;
            end
        end
        if (dropped)
            m_ovf = 1'b1;
        else if (oc)
            m_ovf = 1'b0;
        m_irq = irq_n;
        check_all(tag);
        bus.wr_en         = 1'b0;
        bus.tx_data_ready = 1'b0;
        bus.flush         = 1'b0;
        bus.ovf_clr       = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] first;
        int pushed;
        bus.wr_en         = 1'b0;
        bus.wr_data       = '0;
        bus.tx_data_ready = 1'b0;
        bus.flush         = 1'b0;
        bus.ovf_clr       = 1'b0;

        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
`ifdef UART_TX_FIFO_LEVEL_IRQ_EN
        m_irq = 1'b1;
`endif
        check_all("post_reset");

        cyc("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cyc("push_3c", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        cyc("push_7e", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        chk("three.head", 32'(bus.tx_data), 32'h A5);
        chk("three.level", 32'(bus.level), 32'd3);

        for (int i = 0; i < 3; i++)
            cyc("pop3", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("pop3.send", 32'(bus.send), 32'd0);

        first = 8'($urandom);
        cyc("fill", 1'b1, first, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++)
            cyc("fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        chk("fill.full", 32'(bus.full), 32'd1);
        cyc("drop_ff", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("drop.ovf", 32'(bus.overflow), 32'd1);
        chk("drop.head", 32'(bus.tx_data), 32'(first));
        cyc("ovf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr.ovf", 32'(bus.overflow), 32'd0);

        cyc("full_pp", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk("full_pp.level", 32'(bus.level), 32'd16);
        for (int i = 0; i < DEPTH; i++)
            cyc("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        pushed = 0;
        for (int i = 0; i < 200 && (pushed < 20 || q.size() != 0); i++) begin
            logic wr;
            wr = (pushed < 20) && ($urandom_range(0, 1) == 1);
            if (wr)
                pushed++;
            d = 8'($urandom);
            cyc("wrap", wr, d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        chk("wrap.done", 32'(q.size()), 32'd0);

        for (int i = 0; i < 5; i++)
            cyc("pre_flush", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        cyc("flush", 1'b1, 8'h99, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++)
            cyc("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.send", 32'(bus.send), 32'd0);
        chk("async_rst.level", 32'(bus.level), 32'd0);
        chk("async_rst.tx_data", 32'(bus.tx_data), 32'd0);
        q.delete();
        m_ovf = 1'b0;
        m_irq = 1'b0;
        @(posedge clk);
        #1;
        check_all("in_rst");
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            cyc("irq_fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc("irq_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
